// File: rtl/fetch_ctrl_if.sv
// Signal bundle between fetch_ctrl and its surroundings: decoder/ALU flags in,
// fetch-unit controls, datapath strobes and performance counters out.
interface fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             Go;
    logic             Dec_Branch;
    logic             Dec_Halt;
    logic             Zero_Flag;
    logic [7:0]       Dec_Offset;

    logic             start;
    logic             Halt;
    logic             Branch;
    logic [7:0]       Target;
    logic             IR_Load;
    logic             Exec_En;
    logic             Done;
    logic [CNT_W-1:0] Instr_Count;
    logic [CNT_W-1:0] Cycle_Count;

    // The controller itself.
    modport master (
        input  Go, Dec_Branch, Dec_Halt, Zero_Flag, Dec_Offset,
        output start, Halt, Branch, Target, IR_Load, Exec_En, Done,
        output Instr_Count, Cycle_Count
    );

    // Decoder, fetch unit and datapath side.
    modport slave (
        output Go, Dec_Branch, Dec_Halt, Zero_Flag, Dec_Offset,
        input  start, Halt, Branch, Target, IR_Load, Exec_En, Done,
        input  Instr_Count, Cycle_Count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Sequencing controller for the 8-bit fetch unit: one PC step per executed
// instruction, a fixed instruction-memory wait, and saturating perf counters.
module fetch_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic         CLK,
    input  logic         Reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FETCH,
        EXEC,
        DONE
    } state_t;

    localparam logic [3:0]       WAIT_LOAD = 4'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wait_cnt;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;
    logic             take_branch;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign take_branch = bus.Dec_Branch & bus.Zero_Flag;

    // NOTE: every output gets a default before the case, so no path leaves one unassigned.
    always_comb begin
        state_nxt   = state;
        bus.start   = 1'b0;
        bus.Halt    = 1'b1;
        bus.Branch  = 1'b0;
        bus.Target  = 8'h00;
        bus.IR_Load = 1'b0;
        bus.Exec_En = 1'b0;
        bus.Done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Go) state_nxt = INIT;
            end
            INIT: begin
                bus.start = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                if (wait_cnt == 4'd0) begin
                    bus.IR_Load = 1'b1;
                    state_nxt   = EXEC;
                end
            end
            EXEC: begin
                // A halt wins over a branch and keeps the PC where it is.
                if (bus.Dec_Halt) begin
                    state_nxt = DONE;
                end else begin
                    bus.Halt    = 1'b0;
                    bus.Exec_En = 1'b1;
                    bus.Branch  = take_branch;
                    bus.Target  = take_branch ? bus.Dec_Offset : 8'h00;
                    state_nxt   = FETCH;
                end
            end
            DONE: begin
                bus.Done = 1'b1;
                if (bus.Go) state_nxt = INIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                INIT:    wait_cnt <= WAIT_LOAD;
                FETCH:   if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                EXEC:    if (!bus.Dec_Halt) wait_cnt <= WAIT_LOAD;
                default: wait_cnt <= wait_cnt;
            endcase
        end
    end

    // Counters clear at the start of every run and stick at all-ones.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else if (state == INIT) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if ((state == FETCH || state == EXEC) && cycle_count != CNT_MAX)
                cycle_count <= cycle_count + CNT_W'(1);
            if (state == EXEC && instr_count != CNT_MAX)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign bus.Instr_Count = instr_count;
    assign bus.Cycle_Count = cycle_count;

    // PC clear must never coincide with a PC step, and capture never overlaps execute.
    a_start_halts: assert property (@(posedge CLK) disable iff (Reset) bus.start |-> bus.Halt);
    a_load_exec:   assert property (@(posedge CLK) disable iff (Reset) !(bus.IR_Load && bus.Exec_En));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: random programs feed a scoreboard of per-fetch and per-run
// expectations; a fetch-unit model tracks the PC the controller steers.
module tb_fetch_ctrl;
    localparam int ML  = 2;
    localparam int W   = 16;
    localparam int SML = 1;
    localparam int SW  = 4;

    typedef struct {
        bit         halt;
        bit         br;
        bit         z;
        logic [7:0] off;
    } instr_t;

    typedef struct {
        int         cyc;
        logic [7:0] pc;
        int         icnt;
        int         ccnt;
        bit         halt;
        bit         br;
        logic [7:0] tgt;
    } fetch_exp_t;

    typedef struct {
        int         go_cyc;
        int         done_cyc;
        int         icnt;
        int         ccnt;
        logic [7:0] pc;
    } run_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   sat_k = 0;
    logic [7:0] fetch_pc;

    instr_t     prog[$];
    instr_t     prog_q[$];
    fetch_exp_t exp_q[$];
    run_exp_t   run_q[$];
    fetch_exp_t sat_q[$];
    run_exp_t   sat_run_q[$];

    fetch_ctrl_if #(.CNT_W(W))  bus ();
    fetch_ctrl_if #(.CNT_W(SW)) sbus ();

    fetch_ctrl #(.MEM_LAT(ML), .CNT_W(W)) u_dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    fetch_ctrl #(.MEM_LAT(SML), .CNT_W(SW)) u_sat (
        .CLK   (clk),
        .Reset (rst),
        .bus   (sbus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fetch unit: start clears, Halt holds, otherwise step by 1 or by the branch offset.
    always @(posedge clk or posedge rst) begin
        if (rst)                fetch_pc <= 8'h00;
        else if (bus.start)     fetch_pc <= 8'h00;
        else if (!bus.Halt)     fetch_pc <= bus.Branch ? fetch_pc + bus.Target : fetch_pc + 8'h01;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic add(input bit halt, input bit br, input bit z, input logic [7:0] off);
        instr_t i;
        i.halt = halt;
        i.br   = br;
        i.z    = z;
        i.off  = off;
        prog.push_back(i);
    endtask

    // Derive the expected trace of a whole run from the program, then pulse/hold Go.
    task automatic launch(input bit on_sat, input int hold);
        int         g, ml, w, n;
        logic [7:0] pc;
        fetch_exp_t e;
        run_exp_t   r;
        ml = on_sat ? SML : ML;
        w  = on_sat ? SW : W;
        n  = prog.size();
        @(negedge clk);
        g  = cyc;
        pc = 8'h00;
        for (int k = 0; k < n; k++) begin
            e.cyc  = g + ml + 1 + k * (ml + 1);
            e.pc   = pc;
            e.icnt = sat(k, w);
            e.ccnt = sat(k * (ml + 1) + ml - 1, w);
            e.halt = prog[k].halt;
            e.br   = !prog[k].halt && prog[k].br && prog[k].z;
            e.tgt  = e.br ? prog[k].off : 8'h00;
            if (on_sat) sat_q.push_back(e);
            else        exp_q.push_back(e);
            if (!e.halt) pc = e.br ? pc + prog[k].off : pc + 8'h01;
        end
        r.go_cyc   = g;
        r.done_cyc = g + 2 + n * (ml + 1);
        r.icnt     = sat(n, w);
        r.ccnt     = sat(n * (ml + 1), w);
        r.pc       = pc;
        if (on_sat) begin
            sat_run_q.push_back(r);
            sat_k   = 0;
            sbus.Go = 1'b1;
        end else begin
            run_q.push_back(r);
            prog_q  = prog;
            bus.Go  = 1'b1;
        end
        repeat (hold + 1) @(negedge clk);
        bus.Go  = 1'b0;
        sbus.Go = 1'b0;
    endtask

    task automatic wait_done(input bit on_sat);
        int t;
        t = 0;
        while (!(on_sat ? sbus.Done : bus.Done) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!(on_sat ? sbus.Done : bus.Done)) begin
            fail_now(on_sat ? "sat_done_timeout" : "done_timeout");
            exp_q.delete();
            run_q.delete();
            prog_q.delete();
            sat_q.delete();
            sat_run_q.delete();
        end
    endtask

    // Decode feeder: real instruction for each EXEC, random noise in every other cycle.
    initial begin
        bit     hold;
        instr_t i;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else if (bus.IR_Load) begin
                if (prog_q.size() > 0) begin
                    i = prog_q.pop_front();
                end else begin
                    i.halt = 1'b1; i.br = 1'b0; i.z = 1'b0; i.off = 8'h00;
                end
                bus.Dec_Halt   = i.halt;
                bus.Dec_Branch = i.br;
                bus.Zero_Flag  = i.z;
                bus.Dec_Offset = i.off;
                hold = 1'b1;
            end else if (hold) begin
                hold = 1'b0;
            end else begin
                bus.Dec_Halt   = 1'($urandom);
                bus.Dec_Branch = 1'($urandom);
                bus.Zero_Flag  = 1'($urandom);
                bus.Dec_Offset = 8'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && sbus.IR_Load) begin
                sbus.Dec_Halt   = (sat_k == 20);
                sbus.Dec_Branch = 1'($urandom);
                sbus.Zero_Flag  = 1'($urandom);
                sbus.Dec_Offset = 8'($urandom);
                sat_k++;
            end
        end
    end

    // Main monitor: pops one expectation per IR_Load and one per Done rising edge.
    initial begin
        bit         in_exec;
        bit         done_q;
        fetch_exp_t cur;
        run_exp_t   r;
        in_exec = 1'b0;
        done_q  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_exec = 1'b0;
                done_q  = 1'b0;
            end else begin
                if (in_exec) begin
                    check("exec_halt",   bus.Halt,    cur.halt);
                    check("exec_en",     bus.Exec_En, !cur.halt);
                    check("exec_branch", bus.Branch,  cur.br);
                    check("exec_target", bus.Target,  cur.tgt);
                end else begin
                    check("quiet_halt",   bus.Halt,    1);
                    check("quiet_branch", bus.Branch,  0);
                    check("quiet_target", bus.Target,  0);
                    check("quiet_exec",   bus.Exec_En, 0);
                end
                in_exec = 1'b0;
                if (bus.IR_Load) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_ir_load");
                    end else begin
                        cur = exp_q.pop_front();
                        check("fetch_cycle", cyc,             cur.cyc);
                        check("fetch_pc",    fetch_pc,        cur.pc);
                        check("fetch_icnt",  bus.Instr_Count, cur.icnt);
                        check("fetch_ccnt",  bus.Cycle_Count, cur.ccnt);
                        in_exec = 1'b1;
                    end
                end
                if (bus.start) begin
                    if (run_q.size() == 0) fail_now("unexpected_start");
                    else check("start_cycle", cyc, run_q[0].go_cyc + 1);
                    check("init_done", bus.Done, 0);
                end
                if (bus.Done && !done_q) begin
                    if (run_q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        r = run_q.pop_front();
                        check("done_cycle",   cyc,             r.done_cyc);
                        check("done_icnt",    bus.Instr_Count, r.icnt);
                        check("done_ccnt",    bus.Cycle_Count, r.ccnt);
                        check("done_pc",      fetch_pc,        r.pc);
                        check("done_pending", exp_q.size(),    0);
                    end
                end
                done_q = bus.Done;
            end
        end
    end

    initial begin
        bit         done_q;
        fetch_exp_t e;
        run_exp_t   r;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_q = 1'b0;
            end else begin
                if (sbus.IR_Load) begin
                    if (sat_q.size() == 0) begin
                        fail_now("sat_unexpected_ir_load");
                    end else begin
                        e = sat_q.pop_front();
                        check("sat_fetch_cycle", cyc,              e.cyc);
                        check("sat_fetch_icnt",  sbus.Instr_Count, e.icnt);
                        check("sat_fetch_ccnt",  sbus.Cycle_Count, e.ccnt);
                    end
                end
                if (sbus.Done && !done_q) begin
                    if (sat_run_q.size() == 0) begin
                        fail_now("sat_unexpected_done");
                    end else begin
                        r = sat_run_q.pop_front();
                        check("sat_done_cycle", cyc,              r.done_cyc);
                        check("sat_done_icnt",  sbus.Instr_Count, r.icnt);
                        check("sat_done_ccnt",  sbus.Cycle_Count, r.ccnt);
                    end
                end
                done_q = sbus.Done;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        bus.Go = 1'b0;  bus.Dec_Halt = 1'b0;  bus.Dec_Branch = 1'b0;
        bus.Zero_Flag = 1'b0;  bus.Dec_Offset = 8'h00;
        sbus.Go = 1'b0; sbus.Dec_Halt = 1'b0; sbus.Dec_Branch = 1'b0;
        sbus.Zero_Flag = 1'b0; sbus.Dec_Offset = 8'h00;

        // Reset, then five idle cycles with Go low.
        repeat (2) @(negedge clk);
        check("rst_halt",  bus.Halt,        1);
        check("rst_start", bus.start,       0);
        check("rst_done",  bus.Done,        0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_halt",  bus.Halt,        1);
        check("idle_start", bus.start,       0);
        check("idle_done",  bus.Done,        0);
        check("idle_load",  bus.IR_Load,     0);
        check("idle_icnt",  bus.Instr_Count, 0);
        check("idle_ccnt",  bus.Cycle_Count, 0);

        // Three plain instructions and a halt.
        prog.delete();
        repeat (3) add(1'b0, 1'b0, 1'b1, 8'h05);
        add(1'b1, 1'b0, 1'b0, 8'h00);
        launch(1'b0, 0);
        wait_done(1'b0);

        // Restart from DONE with Go held; taken branch at PC 5, then not-taken at PC 5.
        prog.delete();
        repeat (5) add(1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 8'hFD);
        repeat (3) add(1'b0, 1'b0, 1'b1, 8'h00);
        add(1'b0, 1'b1, 1'b0, 8'hFD);
        add(1'b1, 1'b1, 1'b1, 8'h40);
        repeat (2) @(negedge clk);
        launch(1'b0, 5);
        wait_done(1'b0);

        for (int run = 0; run < 10; run++) begin
            prog.delete();
            n = $urandom_range(2, 12);
            for (int k = 0; k < n; k++)
                add(k == n - 1, 1'($urandom), 1'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(1'b0, $urandom_range(0, 5));
            wait_done(1'b0);
        end

        // Reset in the second FETCH cycle of a run.
        prog.delete();
        repeat (4) add(1'b0, 1'b1, 1'b1, 8'h10);
        add(1'b1, 1'b0, 1'b0, 8'h00);
        launch(1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_halt",   bus.Halt,        1);
        check("mid_rst_start",  bus.start,       0);
        check("mid_rst_branch", bus.Branch,      0);
        check("mid_rst_target", bus.Target,      0);
        check("mid_rst_load",   bus.IR_Load,     0);
        check("mid_rst_exec",   bus.Exec_En,     0);
        check("mid_rst_done",   bus.Done,        0);
        check("mid_rst_icnt",   bus.Instr_Count, 0);
        check("mid_rst_ccnt",   bus.Cycle_Count, 0);
        exp_q.delete();
        run_q.delete();
        prog_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_load",  bus.IR_Load, 0);
        check("post_rst_start", bus.start,   0);
        check("post_rst_done",  bus.Done,    0);
        check("post_rst_pc",    fetch_pc,    0);

        prog.delete();
        n = $urandom_range(3, 10);
        for (int k = 0; k < n; k++)
            add(k == n - 1, 1'($urandom), 1'($urandom), 8'($urandom));
        launch(1'b0, 1);
        wait_done(1'b0);

        // Twenty instructions and a halt on the narrow-counter, single-wait instance.
        prog.delete();
        repeat (20) add(1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'h00);
        launch(1'b1, 0);
        wait_done(1'b1);
        @(negedge clk);
        check("sat_final_icnt", sbus.Instr_Count, 15);
        check("sat_final_ccnt", sbus.Cycle_Count, 15);
        check("sat_final_done", sbus.Done,        1);

        check("left_fetch", exp_q.size(),     0);
        check("left_run",   run_q.size(),     0);
        check("left_sat",   sat_q.size(),     0);
        check("left_satrun", sat_run_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
